// File: rtl/kernel_pkg.sv
// Shared helpers for the kernel pipe join slice: lane packing and counter sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package kernel_pkg;

  // Default geometry of a TyBEC pass-through / delay-balancing node
  localparam int DEF_STREAMW = 34;
  localparam int DEF_NIN     = 2;
  localparam int DEF_DEPTH   = 3;
  localparam int DEF_OCCW    = 3;

  // Low bit index of lane k inside a flat NIN*STREAMW bus
  function automatic int lane_lo(input int k, input int streamw);
    return k * streamw;
  endfunction

  // Minimum occupancy counter width able to count 0..depth
  function automatic int occw_min(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/kernel_pipe_stage.sv
// One elastic register slice: holds a token and its valid flag.
// Latency: 1 cycle when the slice advances.
// Backpressure: loads when downstream advances or when empty (bubble collapse); otherwise holds.
module kernel_pipe_stage #(
  parameter int W = 68
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_v,
  input  logic         adv_in,
  output logic [W-1:0] out_data,
  output logic         out_v,
  output logic         adv_out
);

  logic [W-1:0] r_data;
  logic         r_v;

  // An empty slice may always load, so its upstream can advance too
  assign adv_out  = adv_in | ~r_v;
  assign out_data = r_data;
  assign out_v    = r_v;

  // Load the upstream token on advance, hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_v    <= 1'b0;
    end else if (adv_out) begin
      r_data <= in_data;
      r_v    <= in_v;
    end
  end

endmodule

// File: rtl/kernel_pipe_join.sv
// Joins NIN lanes into one token and carries it through a DEPTH-slice elastic pipeline.
// Latency: DEPTH cycles unstalled; 1 token/cycle throughput.
// Backpressure: iready falls only when every slice is full and oready is low; tokens compress behind a stall.
module kernel_pipe_join
  import kernel_pkg::*;
#(
  parameter int STREAMW = DEF_STREAMW,
  parameter int NIN     = DEF_NIN,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int OCCW    = DEF_OCCW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NIN-1:0]         ivalid_in,
  input  logic [NIN*STREAMW-1:0] in_flat,
  output logic                   iready,
  output logic                   ovalid,
  output logic [NIN*STREAMW-1:0] out_flat,
  input  logic                   oready,
  output logic [OCCW-1:0]        occ
);

  localparam int FW = NIN * STREAMW;

  logic          w_ivalid_all;
  logic          w_acc;
  logic          w_fire;
  logic [FW-1:0] w_data [DEPTH];
  logic          w_v    [DEPTH];
  // w_adv[k] is the advance of slice k; w_adv[DEPTH] is the downstream ready
  logic          w_adv  [DEPTH+1];
  logic [OCCW-1:0] r_occ;

  // A token exists only when every lane is valid together
  assign w_ivalid_all = &ivalid_in;
  assign w_adv[DEPTH] = oready;

  // Ready ripples combinationally from oready down the advance chain
  assign iready = ~rst & w_adv[0];
  assign w_acc  = w_ivalid_all & iready;
  assign w_fire = w_v[DEPTH-1] & oready;

  assign ovalid   = w_v[DEPTH-1];
  assign out_flat = w_data[DEPTH-1];
  assign occ      = r_occ;

  genvar k;
  generate
    for (k = 0; k < DEPTH; k++) begin : g_stage
      logic [FW-1:0] w_src_data;
      logic          w_src_v;
      if (k == 0) begin : g_head
        assign w_src_data = in_flat;
        assign w_src_v    = w_ivalid_all;
      end else begin : g_body
        assign w_src_data = w_data[k-1];
        assign w_src_v    = w_v[k-1];
      end
      kernel_pipe_stage #(.W(FW)) u_stage (
        .clk      (clk),
        .rst      (rst),
        .in_data  (w_src_data),
        .in_v     (w_src_v),
        .adv_in   (w_adv[k+1]),
        .out_data (w_data[k]),
        .out_v    (w_v[k]),
        .adv_out  (w_adv[k])
      );
    end
  endgenerate

  // Occupancy tracks accepts minus drains; simultaneous accept and drain cancel
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ <= '0;
    end else begin
      case ({w_acc, w_fire})
        2'b10:   r_occ <= r_occ + OCCW'(1);
        2'b01:   r_occ <= r_occ - OCCW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_pipe_join.sv
module tb_kernel_pipe_join;
  import kernel_pkg::*;

  localparam int STREAMW = 34;
  localparam int NIN     = 2;
  localparam int DEPTH   = 3;
  localparam int OCCW    = 3;
  localparam int FW      = NIN * STREAMW;

  logic          clk = 1'b0;
  logic          rst;
  logic [NIN-1:0] ivalid_in;
  logic [FW-1:0] in_flat;
  logic          iready;
  logic          ovalid;
  logic [FW-1:0] out_flat;
  logic          oready;
  logic [OCCW-1:0] occ;

  always #5 clk = ~clk;

  kernel_pipe_join #(
    .STREAMW (STREAMW),
    .NIN     (NIN),
    .DEPTH   (DEPTH),
    .OCCW    (OCCW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ivalid_in (ivalid_in),
    .in_flat   (in_flat),
    .iready    (iready),
    .ovalid    (ovalid),
    .out_flat  (out_flat),
    .oready    (oready),
    .occ       (occ)
  );

  // Reference model: FIFO of in-flight tokens, each tagged with the edge that accepted it.
  // A token is visible at the output once it is oldest and DEPTH-1 edges have passed since acceptance.
  typedef struct {
    logic [FW-1:0] data;
    int            acc_edge;
  } tok_t;

  tok_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_out = 0;
  bit   started = 0;
  bit   reset_edge = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [FW-1:0] rnd_flat();
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < NIN; k++)
      f[lane_lo(k, STREAMW) +: STREAMW] = STREAMW'({$urandom(), $urandom()});
    return f;
  endfunction

  function automatic logic [FW-1:0] tag_flat(input int v);
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < NIN; k++)
      f[lane_lo(k, STREAMW) +: STREAMW] = STREAMW'(v);
    return f;
  endfunction

  // Monitor: compares DUT outputs against the model mid-cycle, then advances the model for the next edge
  always @(negedge clk) begin
    bit vexp, acc, fire;
    vexp = 1'b0;
    if (started) begin
      vexp = (q.size() > 0) && (cyc - q[0].acc_edge >= DEPTH - 1);
      chk("ovalid", ovalid, vexp);
      chk("occ", occ, q.size());
      chk("iready", iready, !rst && !(q.size() == DEPTH && !oready));
      if (vexp && ovalid) chk("out_flat", out_flat, q[0].data);
      if (reset_edge) chk("reset_out_flat", out_flat, '0);
    end
    acc  = (&ivalid_in) && iready;
    fire = vexp && oready;
    if (rst) begin
      q.delete();
      started    = 1'b1;
      reset_edge = 1'b1;
    end else begin
      reset_edge = 1'b0;
      if (started) begin
        if (fire) begin
          void'(q.pop_front());
          n_out++;
        end
        if (acc) q.push_back('{data: in_flat, acc_edge: cyc + 1});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ivalid_in = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int tok;
    rst       = 1'b1;
    ivalid_in = NIN'($urandom());
    in_flat   = rnd_flat();
    oready    = 1'($urandom());

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      ivalid_in = NIN'($urandom());
      in_flat   = rnd_flat();
      oready    = 1'($urandom());
      step();
    end
    rst       = 1'b0;
    ivalid_in = '0;
    oready    = 1'b1;
    step();

    // Single token latency
    ivalid_in = '1;
    in_flat   = {34'h1_2345_6789, 34'h0_0000_00AB};
    step();
    idle(5);

    // Unstalled burst 1..8
    for (int i = 1; i <= 8; i++) begin
      ivalid_in = '1;
      in_flat   = tag_flat(i);
      step();
    end
    idle(5);

    // Back-pressure: oready low for phase cycles 2..7, tokens held until accepted
    tok = 1;
    for (int c = 0; c < 40; c++) begin
      oready    = !(c >= 2 && c <= 7);
      ivalid_in = (tok <= 8) ? '1 : '0;
      in_flat   = tag_flat(16 + tok);
      @(negedge clk);
      if ((&ivalid_in) && iready) tok++;
      step();
    end
    chk("bp_all_sent", tok, 9);
    oready = 1'b1;
    idle(4);

    // Partial join: lane 0 only, then all lanes for one cycle
    for (int i = 0; i < 4; i++) begin
      ivalid_in = NIN'(1);
      in_flat   = tag_flat(100 + i);
      step();
    end
    ivalid_in = '1;
    in_flat   = tag_flat(200);
    step();
    idle(5);

    // Mid-operation reset with three tokens stalled inside
    oready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ivalid_in = '1;
      in_flat   = tag_flat(300 + i);
      step();
    end
    ivalid_in = '0;
    rst = 1'b1;
    step();
    rst    = 1'b0;
    oready = 1'b1;
    idle(8);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      ivalid_in = ($urandom_range(3) != 0) ? '1 : NIN'($urandom());
      in_flat   = rnd_flat();
      oready    = ($urandom_range(2) != 0);
      step();
    end
    oready = 1'b1;
    idle(10);

    chk("drained", q.size(), 0);
    chk("outputs_seen", (n_out > 20), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kernel_pipe_join.md
# kernel_pipe_join

Parametrised streaming kernel top-level stage for TyBEC-generated datapaths. It joins NIN input streams, which must all be valid together, and carries them through a DEPTH-stage elastic register pipeline with full valid/ready back-pressure. It also reports pipeline occupancy. It sits between upstream leaf map nodes and downstream consumers, wherever a pass-through or delay-balancing kernel node is required.

## Interface
Parameters:
- STREAMW, 34, width of one stream lane in bits (FP lanes include the 2 flopoco exception bits).
- NIN, 2, number of joined input lanes (>=1).
- DEPTH, 3, number of register stages (>=1); this is the unstalled latency.
- OCCW, 3, occupancy counter width; must be >= clog2(DEPTH+1).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- ivalid_in  in  NIN  per-lane input valid; lane k is bit k.
- in_flat  in  NIN*STREAMW  input lanes; lane k is bits [k*STREAMW +: STREAMW].
- iready  out  1  common ready to all input lanes.
- ovalid  out  1  output token valid.
- out_flat  out  NIN*STREAMW  output lanes, same packing as in_flat.
- oready  in  1  downstream ready.
- occ  out  OCCW  number of valid stages currently held (0..DEPTH).

## Operation
- Join: ivalid_all = &ivalid_in. The block accepts an input token only when ivalid_all & iready. Partial valid (some lanes valid) is never accepted, and all lanes stay in the same token.
- Stages 0..DEPTH-1 each hold data[NIN*STREAMW] and v. Stage DEPTH-1 drives out_flat and ovalid.
- Advance: adv[DEPTH-1] = oready | ~v[DEPTH-1]. For k<DEPTH-1: adv[k] = adv[k+1] | ~v[k].
- Bubbles are collapsed: a stage that is empty always loads.
- Stage 0 loads the input when adv[0]; its v becomes ivalid_all. Stage k loads from stage k-1 when adv[k].
- When a stage does not advance, its data and v hold.
- iready = ~rst & adv[0]. This is a combinational path from oready through the chain; it is accepted at this depth.
- ovalid = v[DEPTH-1]. It is not gated by oready, and once asserted it holds with stable out_flat until oready.
- occ is a registered counter. Per cycle: +1 on input accept without output fire, -1 on output fire (ovalid & oready) without input accept, unchanged otherwise (both or neither). occ must always equal popcount(v).
- Lane data is passed unmodified: no arithmetic, no width change.

## Timing
- Reset (rst=1 at edge): all v=0, all data=0, occ=0. The next cycle gives ovalid=0, out_flat=0, occ=0. iready=0 while rst is high, and iready=1 in the first cycle after rst deasserts.
- Reset mid-operation: all in-flight tokens are discarded and never appear at the output.
- Latency: a token accepted at edge t appears at ovalid/out_flat after edge t+DEPTH-1, i.e. it is visible for consumption DEPTH cycles after acceptance when unstalled.
- Throughput: 1 token/cycle with oready held high.
- Full: all v=1 and oready=0 gives iready=0 and occ=DEPTH.
- Full with oready=1: iready=1 in the same cycle, so simultaneous accept and drain occur and occ is unchanged.
- Empty: occ=0, ovalid=0, iready=1 regardless of oready.
- oready falling mid-burst: no token is lost or duplicated. Tokens compress into empty stages behind the stalled head.

## Structure
- Shared package: no typedefs are needed. Put the lane packing helper localparams (LANE_LO(k)=k*STREAMW) and the OCCW sizing rule in kernel_pkg.
- One sub-module, kernel_pipe_stage: one elastic slice with ports in_data, in_v, adv_in, out_data, out_v, adv_out (adv_out = adv_in | ~v). Instantiate it DEPTH times with a generate loop.
- The top module holds the join logic, iready, and the occ counter.

## Test plan
- Reset: assert rst 2 cycles with random inputs. Require ovalid=0, out_flat=0, occ=0 and iready=0 during rst; iready=1 in the first cycle after release.
- Latency: DEPTH=3, NIN=2, oready=1, single token {lane1=34'h1_2345_6789, lane0=34'h0_0000_00AB}. Require ovalid exactly 3 cycles after acceptance, matching data, and occ sequence 1,1,1,0.
- Burst: 8 consecutive tokens 1..8 on both lanes with oready=1. Require 8 consecutive outputs 1..8 with no gaps, and iready constantly 1.
- Back-pressure: 8-token stream, oready=0 for cycles 2..7. Require iready=0 once occ=3, ovalid held with stable data, and final output order 1..8 with no loss or duplication.
- Partial join: ivalid_in=2'b01 for 4 cycles, then 2'b11. Require no accept during 2'b01, occ unchanged, exactly one token accepted after.
- Mid-op reset: 3 tokens in flight, rst pulse 1 cycle. Require occ=0 and ovalid=0 after, and none of the 3 tokens ever output.
